// File: rtl/tep_intc.sv
// Prioritized, edge-triggered interrupt controller for the TEP CPU.
// Per-source edge/pending bits feed a fixed-priority select and a REQ/SERVICE handshake.

module tep_intc_src (
  input  logic m_clock,
  input  logic p_reset,
  input  logic irq,
  input  logic clr,
  output logic pend
);
  logic prev;

  // A new edge wins over a concurrent clear, so a request is never lost.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      prev <= 1'b0;
      pend <= 1'b0;
    end else begin
      prev <= irq;
      pend <= (irq & ~prev) | (pend & ~clr);
    end
  end
endmodule

module tep_intc #(
  parameter int          NSRC     = 4,
  parameter logic [15:0] VEC_BASE = 16'hFFE0
) (
  input  logic            m_clock,
  input  logic            p_reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic [1:0]      reg_adrs,
  input  logic [15:0]     reg_wdata,
  input  logic            reg_wr,
  output logic [15:0]     reg_rdata,
  output logic            int_req,
  output logic [15:0]     int_vec,
  input  logic            int_ack,
  input  logic            int_eoi
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

  localparam logic [1:0] A_PEND = 2'd0, A_MASK = 2'd1, A_STAT = 2'd2, A_CTRL = 2'd3;

  state_t          state, state_n;
  logic [2:0]      sel, sel_n, pri;
  logic [NSRC-1:0] pend, mask, elig, sel_oh, pend_clr;
  logic [7:0]      elig8;
  logic            gie, ack_hit;
  logic            unused_wdata;

  assign unused_wdata = &{1'b0, reg_wdata};

  tep_intc_src u_src [NSRC-1:0] (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .irq     (irq_in),
    .clr     (pend_clr),
    .pend    (pend)
  );

  assign ack_hit = (state == S_REQ) && int_ack;

  always_comb begin
    elig   = gie ? (pend & mask) : '0;
    elig8  = '0;
    elig8[NSRC-1:0] = elig;
    sel_oh = '0;
    pri    = '0;
    for (int i = 0; i < NSRC; i++) sel_oh[i] = (sel == 3'(i));
    for (int i = NSRC-1; i >= 0; i--) if (elig[i]) pri = 3'(i);
    pend_clr = ((reg_wr && reg_adrs == A_PEND) ? reg_wdata[NSRC-1:0] : '0)
             | (ack_hit ? sel_oh : '0);
  end

  // sel is only reloaded from IDLE, so a higher-priority arrival never preempts REQ.
  always_comb begin
    state_n = state;
    sel_n   = sel;
    case (state)
      S_IDLE:    if (|elig) begin state_n = S_REQ; sel_n = pri; end
      S_REQ:     if (int_ack) state_n = S_SERVICE;
                 else if (!elig8[sel]) state_n = S_IDLE;
      S_SERVICE: if (int_eoi) state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state <= S_IDLE;
      sel   <= '0;
      mask  <= '0;
      gie   <= 1'b0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      if (reg_wr && reg_adrs == A_MASK) mask <= reg_wdata[NSRC-1:0];
      if (reg_wr && reg_adrs == A_CTRL) gie  <= reg_wdata[0];
    end
  end

  assign int_req = (state == S_REQ);
  assign int_vec = int_req ? VEC_BASE + {12'd0, sel, 1'b0} : 16'd0;

  always_comb begin
    reg_rdata = '0;
    case (reg_adrs)
      A_PEND: reg_rdata[NSRC-1:0] = pend;
      A_MASK: reg_rdata[NSRC-1:0] = mask;
      A_STAT: reg_rdata = {state == S_SERVICE, state == S_REQ, 11'd0, sel};
      A_CTRL: reg_rdata[0] = gie;
      default: reg_rdata = '0;
    endcase
  end
endmodule

// File: doc/tep_intc.md
# tep_intc

Prioritized interrupt controller for the TEP CPU. It collects edge-triggered requests from up to `NSRC` peripheral sources: interval timer, serial RX, serial TX, PS/2 and buttons. It latches them as pending, masks them, and presents one request at a time on the CPU's single interrupt line. It sits in `sys` between the peripherals and `cpu`, and the CPU configures it through a small register port on the I/O bus.

## Interface
- `NSRC`, 4: number of interrupt sources (1..8); index 0 is highest priority
- `VEC_BASE`, 16'hFFE0: vector address of source 0; source k vector = `VEC_BASE + 2*k` (16-bit wrap)
- `m_clock`  in  1  system clock, all state on rising edge
- `p_reset`  in  1  reset, asynchronous, active-low
- `irq_in`  in  NSRC  raw source lines, synchronous to `m_clock`; rising edge = request
- `reg_adrs`  in  2  register select: 0 PEND, 1 MASK, 2 STAT, 3 CTRL
- `reg_wdata`  in  16  write data
- `reg_wr`  in  1  one-cycle write strobe
- `reg_rdata`  out  16  read data, combinational from `reg_adrs`, zero-extended
- `int_req`  out  1  interrupt request to CPU
- `int_vec`  out  16  vector of the presented source, valid while `int_req`=1, else 0
- `int_ack`  in  1  CPU accepts presented interrupt (one-cycle pulse)
- `int_eoi`  in  1  CPU end-of-interrupt (one-cycle pulse)

## Operation
- Edge detect: `prev` register holds last `irq_in` (reset 0); `edge = irq_in & ~prev`. Inputs high at reset release therefore count as an edge in the first clock.
- PEND[NSRC-1:0]: bit set on edge; cleared by write-1-to-clear at `reg_adrs`=0, or by `int_ack` for the presented source. If set and clear hit the same bit in the same cycle, set wins.
- MASK[NSRC-1:0]: read/write; 1 = enabled. Reset 0, so all sources are masked.
- CTRL bit0 GIE: global enable, read/write, reset 0. Other bits read 0.
- STAT: bit15 = state is SERVICE, bit14 = state is REQ, bits[2:0] = `sel` (selected source id), other bits 0.
- `eligible = PEND & MASK`, gated by GIE. The selected source is the lowest set index.
- States:
  - IDLE: if `eligible`≠0, latch `sel` and go to REQ.
  - REQ: `int_req`=1 and `int_vec`=vector(`sel`).
    - `int_ack` → clear PEND[`sel`], go to SERVICE.
    - Otherwise, if GIE=0 or `eligible[sel]`=0 (masked or cleared by software) → withdraw to IDLE.
    - `sel` is frozen in REQ. A higher-priority arrival does not preempt it.
  - SERVICE: `int_req`=0. `int_eoi` → IDLE. Nested interrupts are not supported.
- `int_ack` outside REQ and `int_eoi` outside SERVICE are ignored.
- Register writes with `reg_wr`=0 have no effect. Reads have no side effects.

## Timing
- Reset (asynchronous, `p_reset`=0) forces: state IDLE, PEND=0, MASK=0, GIE=0, `prev`=0, `sel`=0, `int_req`=0, `int_vec`=0. The output `reg_rdata` follows the cleared registers.
- Reset asserted mid-REQ or mid-SERVICE aborts the request immediately; no ack or eoi is needed afterwards.
- A rising edge on `irq_in` sampled at edge N sets PEND at N. IDLE then sees it and enters REQ at N+1, so `int_req` is high from N+1 (2-cycle latency from the input rise).
- `int_ack` sampled at edge M: `int_req` and `int_vec` are 0 after M, and PEND[`sel`] is cleared at M unless a new edge arrives for the same source at M.
- `int_eoi` at edge E: IDLE after E. The next request is high from E+1 at the earliest.
- Withdrawal: a MASK/GIE/PEND write at edge W drops `int_req` after W+1, because the check happens in REQ on the following edge.
- Register writes take effect at the write edge. A read returns the updated value from the next cycle.

## Test plan
- Basic: MASK=4'hF, GIE=1, pulse `irq_in[2]` → `int_req`=1 two edges later with `int_vec`=16'hFFE4. Then `int_ack` → PEND=0 and STAT=16'h8002. Then `int_eoi` → STAT=16'h0002 and `int_req` stays 0.
- Priority: edges on `irq_in[3]` and `irq_in[1]` in the same cycle → vector 16'hFFE2 first. After ack+eoi → 16'hFFE6 is presented, and PEND reads 4'h8 before the second ack.
- Masking/withdraw: MASK=4'h1, edge on `irq_in[1]` → no request and PEND=4'h2. Then write MASK=4'h3 → request with vector 16'hFFE2. Then write MASK=0 before ack → `int_req` falls and state returns to IDLE.
- Collision: during REQ for source 0, assert `int_ack` in the same cycle as a new `irq_in[0]` edge → PEND[0] stays 1, and a second request follows eoi. Write-1-clear PEND concurrent with an edge → the bit stays 1.
- Stray handshakes: `int_ack` in IDLE and `int_eoi` in REQ → no state or PEND change.
- Reset: drop `p_reset` while in SERVICE → all outputs 0 and registers 0 asynchronously. After release with `irq_in[0]` held high, PEND[0]=1 after the first edge but `int_req`=0, because MASK=0 and GIE=0.
